pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter NSTAGE, default 3, tracked stages after ID (1=EX, 2=MEM, 3=WB); legal range 2..6.
REQ-003 SHALL have parameter LOAD_STAGE, default 2, first stage whose load result is forwardable; legal range 1..NSTAGE.
REQ-004 SHALL have parameter MD_LAT, default 4, multi-cycle (mul/div) unit occupancy in cycles; legal range 1..15.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port id_valid, input, 1, ID holds a real instruction.
REQ-008 SHALL have ports id_rs and id_rt, input, REG_AW each, source register addresses.
REQ-009 SHALL have ports id_use_rs and id_use_rt, input, 1 each, the source is actually read.
REQ-010 SHALL have ports id_wr_en (1), id_wr_addr (REG_AW), id_is_load (1), id_is_md (1), inputs, describing the ID instruction.
REQ-011 SHALL have port id_redirect, input, 1, branch taken or jump resolved in ID.
REQ-012 SHALL have port stall_f, output, 1, hold PC and the IF/ID register.
REQ-013 SHALL have port bubble_e, output, 1, inject a NOP into EX this cycle.
REQ-014 SHALL have port flush_d, output, 1, squash the instruction entering ID.
REQ-015 SHALL have ports fwd_rs and fwd_rt, output, 3 each, operand source: 0=register file, k=stage k result.
REQ-016 SHALL have port md_busy, output, 1, multi-cycle unit occupied.

Function
REQ-017 SHALL keep a scoreboard of NSTAGE records {valid, wr_en, wr_addr, is_load}; each cycle record k moves to k+1, and the WB record is discarded.
REQ-018 Record 1 SHALL load the ID fields when id_valid=1 and stall=0; otherwise record 1 SHALL be invalid (bubble).
REQ-019 Each source SHALL match record k when id_use_x=1, record valid, wr_en=1, wr_addr==id_x, and id_x!=0; register 0 never matches.
REQ-020 fwd_x SHALL equal the smallest matching k (youngest producer), or 0 if none; combinational from the current inputs and state.
REQ-021 load_stall SHALL assert when the youngest match for either source is a load with k<LOAD_STAGE.
REQ-022 md_stall SHALL assert when id_valid=1, id_is_md=1, and the occupancy counter is nonzero.
REQ-023 stall SHALL equal id_valid & (load_stall | md_stall); stall_f=bubble_e=stall.
REQ-024 flush_d SHALL equal id_valid & id_redirect & ~stall; a redirect under stall is ignored for that cycle and re-evaluated next cycle.
REQ-025 The occupancy counter SHALL load MD_LAT when an md op issues (id_valid & id_is_md & ~stall), otherwise decrement while nonzero and saturate at 0; md_busy = counter!=0.
REQ-026 An md op issuing in the cycle the counter reaches 1 SHALL stall, and SHALL issue the following cycle.
REQ-027 When id_valid=0, all outputs except fwd_x and md_busy SHALL be 0.
REQ-028 Stalls SHALL introduce no added latency beyond one cycle per blocked cycle; forwarding select SHALL have zero-cycle latency.

Reset
REQ-029 While rst_n=0: all scoreboard records invalid, counter=0; stall_f=bubble_e=flush_d=0, fwd_rs=fwd_rt=0, md_busy=0, independent of clk.
REQ-030 Reset asserted mid-stall SHALL clear the stall within the same cycle; after release the first valid instruction SHALL issue without stall.

Verification
REQ-031 Sequence add $3 then add $4,$3,$5 back-to-back -> fwd_rs=1 in the second cycle; one cycle later, with a gap instruction, fwd_rs=2; no stall.
REQ-032 Sequence lw $8 then add $9,$8,$8 (LOAD_STAGE=2) -> stall_f=bubble_e=1 for exactly 1 cycle, then fwd_rs=fwd_rt=2.
REQ-033 Sequence add $0,... then read of $0 -> fwd=0, no stall; add $7 in EX and lw $7 in MEM -> fwd=1 (youngest producer wins).
REQ-034 mul then mul, MD_LAT=4 -> md_busy high for 4 cycles, and the second mul stalls 4 cycles before it issues.
REQ-035 id_redirect=1 together with a load stall -> flush_d=0 during the stall and flush_d=1 in the cycle the stall clears.
REQ-036 rst_n pulsed low between clock edges during an md stall -> all outputs read 0 immediately; after release a mul issues with no stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: in-order pipeline hazard unit providing forwarding selects, load-use and mul/div stalls, and ID redirect flush
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   id_valid                       ID stage holds a real instruction
//   id_rs, id_rt, id_use_rs/rt     source register addresses and whether each is read
//   id_wr_en, id_wr_addr           destination write of the ID instruction
//   id_is_load, id_is_md           ID instruction is a load / multi-cycle mul-div op
//   id_redirect                    branch or jump resolved taken in ID
//   stall_f, bubble_e              hold PC and IF/ID, inject NOP into EX
//   flush_d                        squash the instruction entering ID
//   fwd_rs, fwd_rt                 operand source: 0 = register file, k = stage k result
//   md_busy                        multi-cycle unit occupied
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int NSTAGE = 3,
  parameter int LOAD_STAGE = 2,
  parameter int MD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              id_is_md,
  input  logic              id_redirect,
  output logic              stall_f,
  output logic              bubble_e,
  output logic              flush_d,
  output logic [2:0]        fwd_rs,
  output logic [2:0]        fwd_rt,
  output logic              md_busy
);
  logic [NSTAGE:1]   recValid, recWrEn, recIsLoad;
  logic [REG_AW-1:0] recWrAddr [1:NSTAGE];
  logic [3:0]        mdCnt;
  logic [2:0]        fwdRs, fwdRt;
  logic              rsLoad, rtLoad, loadStall, mdStall, stall, issue;
  // Scan oldest to youngest so the youngest producer overwrites older matches;
  // the load flag tracks whichever record finally won.
  always_comb begin
    fwdRs = '0;
    fwdRt = '0;
    rsLoad = 1'b0;
    rtLoad = 1'b0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (id_use_rs && id_rs != '0 && recValid[k] && recWrEn[k] && recWrAddr[k] == id_rs) begin
        fwdRs = 3'(k);
        rsLoad = recIsLoad[k] && k < LOAD_STAGE;
      end
      if (id_use_rt && id_rt != '0 && recValid[k] && recWrEn[k] && recWrAddr[k] == id_rt) begin
        fwdRt = 3'(k);
        rtLoad = recIsLoad[k] && k < LOAD_STAGE;
      end
    end
  end
  assign loadStall = rsLoad | rtLoad;
  assign mdStall = id_valid & id_is_md & (mdCnt != 4'd0);
  assign stall = id_valid & (loadStall | mdStall);
  assign issue = id_valid & ~stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recValid <= '0;
      recWrEn <= '0;
      recIsLoad <= '0;
      for (int k = 1; k <= NSTAGE; k++) recWrAddr[k] <= '0;
      mdCnt <= '0;
    end else begin
      recValid <= {recValid[NSTAGE-1:1], issue};
      recWrEn <= {recWrEn[NSTAGE-1:1], id_wr_en};
      recIsLoad <= {recIsLoad[NSTAGE-1:1], id_is_load};
      recWrAddr[1] <= id_wr_addr;
      for (int k = 2; k <= NSTAGE; k++) recWrAddr[k] <= recWrAddr[k-1];
      mdCnt <= (issue & id_is_md) ? 4'(MD_LAT) : mdCnt - 4'(mdCnt != 4'd0);
    end
  end
  // Cleared state already forces stalls, forwards and busy to 0 in reset;
  // flush depends only on inputs, so it is gated by rst_n directly.
  assign stall_f = stall;
  assign bubble_e = stall;
  assign flush_d = rst_n & id_valid & id_redirect & ~stall;
  assign fwd_rs = fwdRs;
  assign fwd_rt = fwdRt;
  assign md_busy = mdCnt != 4'd0;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queued scoreboard for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic idValid = 1'b0, useRs = 1'b0, useRt = 1'b0, wrEn = 1'b0, isLoad = 1'b0, isMd = 1'b0, redirect = 1'b0;
  logic [4:0] rs = '0, rt = '0, wrAddr = '0;
  logic stallF, bubbleE, flushD, mdBusy;
  logic [2:0] fwdRs, fwdRt;
  typedef struct {
    string      name;
    logic       s;
    logic       f;
    logic [2:0] fr;
    logic [2:0] ft;
    logic       b;
  } exp_t;
  exp_t q[$];
  logic chk = 1'b0;
  int applied = 0, miscompares = 0;
  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs(rs), .id_rt(rt),
    .id_use_rs(useRs), .id_use_rt(useRt), .id_wr_en(wrEn), .id_wr_addr(wrAddr),
    .id_is_load(isLoad), .id_is_md(isMd), .id_redirect(redirect),
    .stall_f(stallF), .bubble_e(bubbleE), .flush_d(flushD),
    .fwd_rs(fwdRs), .fwd_rt(fwdRt), .md_busy(mdBusy)
  );
  always #5 clk = ~clk;
  task automatic vec(input string n, input logic v, input logic [4:0] a, b, input logic ua, ub, we,
                     input logic [4:0] wa, input logic ld, md, rd,
                     input logic s, f, input logic [2:0] fr, ft, input logic bz);
    exp_t e;
    @(posedge clk);
    #1;
    idValid = v; rs = a; rt = b; useRs = ua; useRt = ub; wrEn = we; wrAddr = wa;
    isLoad = ld; isMd = md; redirect = rd;
    e.name = n; e.s = s; e.f = f; e.fr = fr; e.ft = ft; e.b = bz;
    q.push_back(e);
    chk = 1'b1;
  endtask
  always @(negedge clk) begin
    if (chk) begin
      applied++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard: output present but no expected entry queued");
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({stallF, bubbleE, flushD, fwdRs, fwdRt, mdBusy} !== {e.s, e.s, e.f, e.fr, e.ft, e.b}) begin
          miscompares++;
          $display("FAIL %s: got stall_f=%b bubble_e=%b flush_d=%b fwd_rs=%0d fwd_rt=%0d md_busy=%b, need stall=%b flush_d=%b fwd_rs=%0d fwd_rt=%0d md_busy=%b",
                   e.name, stallF, bubbleE, flushD, fwdRs, fwdRt, mdBusy, e.s, e.f, e.fr, e.ft, e.b);
        end
      end
    end
  end
  initial begin
    vec("reset",  1, 1, 2, 1, 1, 1, 3, 0, 1, 1,  0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    idValid = 1'b0; redirect = 1'b0; isMd = 1'b0;
    rst_n = 1'b1;
    vec("add3",   1, 1, 2, 1, 1, 1, 3, 0, 0, 0,  0, 0, 0, 0, 0);
    vec("fwd1",   1, 3, 5, 1, 1, 1, 4, 0, 0, 0,  0, 0, 1, 0, 0);
    vec("gap",    1, 1, 2, 1, 1, 1, 6, 0, 0, 0,  0, 0, 0, 0, 0);
    vec("fwd2wb", 1, 4, 3, 1, 1, 1, 7, 0, 0, 0,  0, 0, 2, 3, 0);
    vec("wr0",    1, 1, 2, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vec("rd0",    1, 0, 0, 1, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("lw7",    1, 1, 2, 1, 1, 1, 7, 1, 0, 0,  0, 0, 0, 0, 0);
    vec("add7",   1, 1, 2, 1, 1, 1, 7, 0, 0, 0,  0, 0, 0, 0, 0);
    vec("young",  1, 7, 7, 1, 1, 1, 13, 0, 0, 0, 0, 0, 1, 1, 0);
    vec("lw8",    1, 1, 2, 1, 1, 1, 8, 1, 0, 0,  0, 0, 0, 0, 0);
    vec("ldstall",1, 8, 8, 1, 1, 1, 9, 0, 0, 0,  1, 0, 1, 1, 0);
    vec("ldfwd",  1, 8, 8, 1, 1, 1, 9, 0, 0, 0,  0, 0, 2, 2, 0);
    vec("lw14",   1, 1, 2, 1, 1, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0);
    vec("brstall",1, 14, 2, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    vec("brflush",1, 14, 2, 1, 0, 0, 0, 0, 0, 1, 0, 1, 2, 0, 0);
    vec("idle",   0, 14, 2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 3, 0, 0);
    vec("mul15",  1, 1, 2, 1, 1, 1, 15, 0, 1, 0, 0, 0, 0, 0, 0);
    vec("mdst1",  1, 15, 1, 1, 1, 1, 16, 0, 1, 0, 1, 0, 1, 0, 1);
    vec("mdst2",  1, 15, 1, 1, 1, 1, 16, 0, 1, 0, 1, 0, 2, 0, 1);
    vec("mdst3",  1, 15, 1, 1, 1, 1, 16, 0, 1, 0, 1, 0, 3, 0, 1);
    vec("mdst4",  1, 15, 1, 1, 1, 1, 16, 0, 1, 0, 1, 0, 0, 0, 1);
    vec("mdissue",1, 15, 1, 1, 1, 1, 16, 0, 1, 0, 0, 0, 0, 0, 0);
    vec("mul17",  1, 1, 2, 1, 1, 1, 17, 0, 1, 1, 1, 0, 0, 0, 1);
    vec("rstmid", 1, 1, 2, 1, 1, 1, 17, 0, 1, 1, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    vec("postrst",0, 17, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vec("postrs2",0, 17, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
    @(negedge clk);
    #1 chk = 1'b0;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries never checked, need 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
